// File: rtl/bcd7seg_scan_driver_pkg.sv
// Shared segment patterns and helpers for the scanned BCD 7-segment driver.
// All patterns are active-high, ordered {g,f,e,d,c,b,a}.
package bcd7seg_scan_driver_pkg;

  localparam logic [6:0] SEG_0   = 7'h3F;
  localparam logic [6:0] SEG_1   = 7'h06;
  localparam logic [6:0] SEG_2   = 7'h5B;
  localparam logic [6:0] SEG_3   = 7'h4F;
  localparam logic [6:0] SEG_4   = 7'h66;
  localparam logic [6:0] SEG_5   = 7'h6D;
  localparam logic [6:0] SEG_6   = 7'h7D;
  localparam logic [6:0] SEG_7   = 7'h07;
  localparam logic [6:0] SEG_8   = 7'h7F;
  localparam logic [6:0] SEG_9   = 7'h6F;
  localparam logic [6:0] SEG_ALL = 7'h7F;
  localparam logic [6:0] SEG_OFF = 7'h00;

  // Nibbles above 9 decode to dark.
  function automatic logic [6:0] bcd_pat(input logic [3:0] nib);
    case (nib)
      4'd0:    bcd_pat = SEG_0;
      4'd1:    bcd_pat = SEG_1;
      4'd2:    bcd_pat = SEG_2;
      4'd3:    bcd_pat = SEG_3;
      4'd4:    bcd_pat = SEG_4;
      4'd5:    bcd_pat = SEG_5;
      4'd6:    bcd_pat = SEG_6;
      4'd7:    bcd_pat = SEG_7;
      4'd8:    bcd_pat = SEG_8;
      4'd9:    bcd_pat = SEG_9;
      default: bcd_pat = SEG_OFF;
    endcase
  endfunction

endpackage

// File: rtl/bcd7seg_scan_driver_decode.sv
// Single-digit decoder: blanking beats lamp test beats suppression beats the BCD pattern.
module bcd7seg_decode
  import bcd7seg_scan_driver_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       lt_n,
  input  logic       bi_n,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    if (!bi_n)       seg = SEG_OFF;
    else if (!lt_n)  seg = SEG_ALL;
    else if (!blank) seg = bcd_pat(nib);
  end

endmodule

// File: rtl/bcd7seg_scan_driver.sv
// Time-multiplexed NDIG-digit 7-segment driver with shadow registers,
// leading-zero suppression, lamp test, blanking and invalid-BCD flag.
module bcd7seg_scan_driver
  import bcd7seg_scan_driver_pkg::*;
#(
  parameter int NDIG     = 4,
  parameter int PRESC    = 1000,
  parameter int SEG_ALOW = 1,
  parameter int AN_ALOW  = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [4*NDIG-1:0] bcd,
  input  logic [NDIG-1:0]   dp,
  input  logic              load,
  input  logic              lt_n,
  input  logic              bi_n,
  input  logic              rbi_n,
  output logic [6:0]        seg,
  output logic              dp_o,
  output logic [NDIG-1:0]   an,
  output logic              bcd_err
);

  localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  logic [PW-1:0]           presc;
  logic [IW-1:0]           idx;
  logic                    tick;
  logic [NDIG-1:0][3:0]    sh_bcd;
  logic [NDIG-1:0]         sh_dp;
  logic [NDIG-1:0]         sup;
  logic [NDIG-1:0][6:0]    lane_seg;
  logic                    bad_in;

  logic [6:0]              seg_q;
  logic                    dp_q;
  logic [NDIG-1:0]         an_q;

  assign tick = (presc == PW'(PRESC - 1));

  // Walk from the top digit down; once a nonzero nibble or a dp request is
  // seen, nothing at or below it may be suppressed.
  always_comb begin
    logic keep;
    keep = 1'b0;
    sup  = '0;
    for (int k = NDIG - 1; k >= 1; k--) begin
      keep   = keep | (sh_bcd[k] != 4'd0) | sh_dp[k];
      sup[k] = !rbi_n && !keep;
    end
  end

  always_comb begin
    bad_in = 1'b0;
    for (int k = 0; k < NDIG; k++)
      bad_in = bad_in | (bcd[4*k +: 4] > 4'd9);
  end

  for (genvar k = 0; k < NDIG; k++) begin : g_lane
    bcd7seg_decode u_dec (
      .nib   (sh_bcd[k]),
      .lt_n  (lt_n),
      .bi_n  (bi_n),
      .blank (sup[k]),
      .seg   (lane_seg[k])
    );
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      presc   <= '0;
      idx     <= '0;
      sh_bcd  <= '0;
      sh_dp   <= '0;
      bcd_err <= 1'b0;
      seg_q   <= '0;
      dp_q    <= 1'b0;
      an_q    <= '0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) idx <= (idx == IW'(NDIG - 1)) ? '0 : idx + 1'b1;
      if (load) begin
        sh_bcd  <= bcd;
        sh_dp   <= dp;
        bcd_err <= bad_in;
      end
      seg_q <= lane_seg[idx];
      an_q  <= bi_n ? (NDIG'(1) << idx) : '0;
      if (!bi_n)          dp_q <= 1'b0;
      else if (!lt_n)     dp_q <= 1'b1;
      else if (sup[idx])  dp_q <= 1'b0;
      else                dp_q <= sh_dp[idx];
    end
  end

  assign seg  = (SEG_ALOW != 0) ? ~seg_q : seg_q;
  assign dp_o = (SEG_ALOW != 0) ? ~dp_q  : dp_q;
  assign an   = (AN_ALOW  != 0) ? ~an_q  : an_q;

endmodule

// File: tb/tb_bcd7seg_scan_driver.sv
// Randomised bench for bcd7seg_scan_driver against a cycle-count based reference model.
module tb_bcd7seg_scan_driver;

  localparam int NDIG  = 4;
  localparam int PRESC = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [15:0] bcd = '0;
  logic [3:0]  dp = '0;
  logic        load = 1'b0, lt_n = 1'b1, bi_n = 1'b1, rbi_n = 1'b1;
  logic [6:0]  seg;
  logic        dp_o;
  logic [3:0]  an;
  logic        bcd_err;

  bcd7seg_scan_driver #(.NDIG(NDIG), .PRESC(PRESC), .SEG_ALOW(1), .AN_ALOW(1)) dut (
    .clk(clk), .rstn(rstn), .bcd(bcd), .dp(dp), .load(load),
    .lt_n(lt_n), .bi_n(bi_n), .rbi_n(rbi_n),
    .seg(seg), .dp_o(dp_o), .an(an), .bcd_err(bcd_err)
  );

  always #5 clk = ~clk;

  // active-high views of the pins
  logic [6:0] seg_h;
  logic       dp_h;
  logic [3:0] an_h;
  assign seg_h = ~seg;
  assign dp_h  = ~dp_o;
  assign an_h  = ~an;

  int n_run = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Digit glyphs drawn from the segment layout (a=bit0 .. g=bit6).
  logic [6:0] pat [10];
  initial begin
    pat[0] = 7'b0111111; pat[1] = 7'b0000110; pat[2] = 7'b1011011;
    pat[3] = 7'b1001111; pat[4] = 7'b1100110; pat[5] = 7'b1101101;
    pat[6] = 7'b1111101; pat[7] = 7'b0000111; pat[8] = 7'b1111111;
    pat[9] = 7'b1101111;
  end

  // Model: edges since reset release give the scanned digit arithmetically.
  int          m_cnt = 0;
  logic [15:0] m_bcd = '0;
  logic [3:0]  m_dp = '0;
  logic [6:0]  e_seg = '0;
  logic        e_dp = 1'b0;
  logic [3:0]  e_an = '0;
  logic        e_err = 1'b0;
  bit          chk_on = 1'b0;

  function automatic int cur_digit(input int cnt);
    return (cnt / PRESC) % NDIG;
  endfunction

  always @(posedge clk) begin
    int k, v;
    bit sup;
    if (!rstn) begin
      m_cnt = 0; m_bcd = '0; m_dp = '0;
      e_seg = '0; e_dp = 1'b0; e_an = '0; e_err = 1'b0;
    end else begin
      k   = cur_digit(m_cnt);
      v   = int'((m_bcd >> (4 * k)) & 16'hF);
      sup = !rbi_n && (k > 0) && ((m_bcd >> (4 * k)) == 0) && ((m_dp >> k) == 0);
      if (!bi_n) begin
        e_seg = '0; e_dp = 1'b0; e_an = '0;
      end else begin
        e_an = 4'(1 << k);
        if (!lt_n)       begin e_seg = 7'h7F; e_dp = 1'b1; end
        else if (sup)    begin e_seg = '0;    e_dp = 1'b0; end
        else if (v > 9)  begin e_seg = '0;    e_dp = m_dp[k]; end
        else             begin e_seg = pat[v]; e_dp = m_dp[k]; end
      end
      if (load) begin
        m_bcd = bcd; m_dp = dp; e_err = 1'b0;
        for (int j = 0; j < NDIG; j++)
          if (((bcd >> (4 * j)) & 16'hF) > 9) e_err = 1'b1;
      end
      m_cnt++;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("seg", 32'(seg_h), 32'(e_seg));
      chk("dp_o", 32'(dp_h), 32'(e_dp));
      chk("an", 32'(an_h), 32'(e_an));
      chk("bcd_err", 32'(bcd_err), 32'(e_err));
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    bcd = v; dp = d; load = 1'b1;
    cyc(1);
    load = 1'b0;
  endtask

  initial begin
    int guard;
    chk_on = 1'b1;
    cyc(3);
    chk("rst_an", 32'(an_h), 32'h0);
    chk("rst_seg", 32'(seg_h), 32'h0);
    rstn = 1'b1;
    cyc(1);
    chk("first_an", 32'(an_h), 32'h1);
    cyc(20);

    do_load(16'h1234, 4'h0);
    cyc(20);

    rbi_n = 1'b0;
    do_load(16'h0070, 4'h0);
    cyc(20);
    do_load(16'h0000, 4'h0);
    cyc(20);
    do_load(16'h0000, 4'b0100);
    cyc(20);

    lt_n = 1'b0;
    cyc(20);
    bi_n = 1'b0;
    cyc(10);
    bi_n = 1'b1; lt_n = 1'b1;
    cyc(20);

    do_load(16'h00A5, 4'h0);
    @(negedge clk);
    chk("err_set", 32'(bcd_err), 32'h1);
    cyc(20);
    do_load(16'h0005, 4'h0);
    @(negedge clk);
    chk("err_clr", 32'(bcd_err), 32'h0);

    do_load(16'h9876, 4'hF);
    guard = 0;
    while (cur_digit(m_cnt) != 2 && guard < 64) begin cyc(1); guard++; end
    chk("idx2_reached", 32'(guard < 64), 32'h1);
    rstn = 1'b0;
    cyc(1);
    chk("midrst_an", 32'(an_h), 32'h0);
    chk("midrst_err", 32'(bcd_err), 32'h0);
    rstn = 1'b1;
    cyc(1);
    chk("midrst_an0", 32'(an_h), 32'h1);
    chk("midrst_seg", 32'(seg_h), 32'(pat[0]));

    for (int i = 0; i < 3000; i++) begin
      logic [15:0] v;
      for (int j = 0; j < NDIG; j++)
        v[4*j +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      bcd   = v;
      dp    = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      load  = ($urandom_range(0, 15) == 0);
      lt_n  = ($urandom_range(0, 19) != 0);
      bi_n  = ($urandom_range(0, 19) != 0);
      rbi_n = ($urandom_range(0, 1) != 0);
      rstn  = ($urandom_range(0, 299) != 0);
      cyc(1);
    end

    rstn = 1'b1; load = 1'b0;
    cyc(2);
    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
